// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: grant encoding and default widths.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ARM  = 2'd1,
        GNT_KEY  = 2'd2
    } gnt_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_KQ_DEPTH   = 4;
    localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/ram_port_arbiter_key_write_queue.sv
// Keyboard write FIFO: address/data pairs, registered count drives full/empty.
module key_write_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          pushAddr,
    input  logic [DATA_W-1:0]          pushData,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          headAddr,
    output logic [DATA_W-1:0]          headData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign headAddr = addrMem[rdPtr];
    assign headData = dataMem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; entries become visible solely through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr] <= pushAddr;
            dataMem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between CPU (zero-latency) and queued keyboard writes.
// Optional macro KEY_STARVE_GUARD_EN forces a key write after STARVE_MAX waited cycles.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int KQ_DEPTH   = DEF_KQ_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm_req,
    input  logic                       arm_we,
    input  logic [ADDR_W-1:0]          arm_addr,
    input  logic [DATA_W-1:0]          arm_wdata,
    output logic                       arm_ready,
    output logic [DATA_W-1:0]          arm_rdata,
    input  logic                       key_valid,
    input  logic [ADDR_W-1:0]          key_addr,
    input  logic [DATA_W-1:0]          key_data,
    output logic                       key_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [$clog2(KQ_DEPTH):0]  kq_count,
    output logic                       key_ovf
);

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic              starveForce;
    gnt_t              gnt;

    key_write_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (KQ_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushAddr (key_addr),
        .pushData (key_data),
        .pop      (pop),
        .headAddr (headAddr),
        .headData (headData),
        .count    (kq_count),
        .full     (full),
        .empty    (empty)
    );

    assign key_ready = rst_n && !full;
    assign push      = key_valid && key_ready;
    assign pop       = (gnt == GNT_KEY);

`ifdef KEY_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starveCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (gnt == GNT_KEY || empty) begin
            starveCnt <= '0;
        end else if (starveCnt != SW'(STARVE_MAX)) begin
            starveCnt <= starveCnt + SW'(1);
        end
    end

    assign starveForce = !empty && (starveCnt == SW'(STARVE_MAX));
`else
    // Strict CPU priority; STARVE_MAX has no effect in this build.
    assign starveForce = (STARVE_MAX < 0);
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (!rst_n)          gnt = GNT_NONE;
        else if (starveForce) gnt = GNT_KEY;
        else if (arm_req)    gnt = GNT_ARM;
        else if (!empty)     gnt = GNT_KEY;
    end

    always_comb begin
        arm_ready = 1'b0;
        arm_rdata = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_ARM: begin
                arm_ready = 1'b1;
                arm_rdata = mem_rdata;
                mem_we    = arm_we;
                mem_addr  = arm_addr;
                mem_wdata = arm_wdata;
            end
            GNT_KEY: begin
                mem_we    = 1'b1;
                mem_addr  = headAddr;
                mem_wdata = headData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_ovf <= 1'b0;
        end else if (key_valid && !key_ready) begin
            key_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM.
module tb_ram_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int KQ_DEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              rst_n;
    logic              arm_req;
    logic              arm_we;
    logic [ADDR_W-1:0] arm_addr;
    logic [DATA_W-1:0] arm_wdata;
    logic              arm_ready;
    logic [DATA_W-1:0] arm_rdata;
    logic              key_valid;
    logic [ADDR_W-1:0] key_addr;
    logic [DATA_W-1:0] key_data;
    logic              key_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [$clog2(KQ_DEPTH):0] kq_count;
    logic              key_ovf;

    logic [DATA_W-1:0] ram [16];
    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .KQ_DEPTH   (KQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm_req   (arm_req),
        .arm_we    (arm_we),
        .arm_addr  (arm_addr),
        .arm_wdata (arm_wdata),
        .arm_ready (arm_ready),
        .arm_rdata (arm_rdata),
        .key_valid (key_valid),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .key_ready (key_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .kq_count  (kq_count),
        .key_ovf   (key_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[3:0]];
    always @(posedge clk) if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit after it, checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        rst_n = 1'b0; arm_req = 1'b1; arm_we = 1'b1; arm_addr = 7; arm_wdata = 32'h55;
        key_valid = 1'b1; key_addr = 2; key_data = 32'h99;

        // Reset: everything quiet even with live requests
        tick(); settle();
        chk("rst_key_ready", key_ready, 0);
        chk("rst_arm_ready", arm_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_kq_count", kq_count, 0);
        chk("rst_key_ovf", key_ovf, 0);
        tick();

        rst_n = 1'b1; arm_req = 1'b0; arm_we = 1'b0; key_valid = 1'b0; settle();
        chk("idle_key_ready", key_ready, 1);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, 0);

        // Key write 0x41 -> addr 5
        key_valid = 1'b1; key_addr = 5; key_data = 32'h41; settle();
        chk("kw_same_cycle_we", mem_we, 0);
        chk("kw_count0", kq_count, 0);
        tick(); key_valid = 1'b0; settle();
        chk("kw_count1", kq_count, 1);
        chk("kw_mem_we", mem_we, 1);
        chk("kw_mem_addr", mem_addr, 5);
        chk("kw_mem_wdata", mem_wdata, 32'h41);
        chk("kw_arm_ready", arm_ready, 0);
        tick(); settle();
        chk("kw_count_drained", kq_count, 0);
        chk("kw_idle_we", mem_we, 0);

        // CPU write 0xDEAD to addr 3, then read it back
        arm_req = 1'b1; arm_we = 1'b1; arm_addr = 3; arm_wdata = 32'hDEAD; settle();
        chk("cw_arm_ready", arm_ready, 1);
        chk("cw_mem_we", mem_we, 1);
        chk("cw_mem_addr", mem_addr, 3);
        chk("cw_mem_wdata", mem_wdata, 32'hDEAD);
        tick(); arm_we = 1'b0; settle();
        chk("cr_arm_ready", arm_ready, 1);
        chk("cr_mem_we", mem_we, 0);
        chk("cr_rdata", arm_rdata, 32'hDEAD);
        tick(); arm_addr = 5; settle();
        chk("cr_key_landed", arm_rdata, 32'h41);

        // Starvation: CPU reads continuously while one key write waits
        arm_addr = 0; key_valid = 1'b1; key_addr = 6; key_data = 32'h77; settle();
        chk("sv_key_ready", key_ready, 1);
        tick(); key_valid = 1'b0;
`ifdef KEY_STARVE_GUARD_EN
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("sv_wait%0d_arm_ready", i), arm_ready, 1);
            chk($sformatf("sv_wait%0d_mem_we", i), mem_we, 0);
            tick();
        end
        settle();
        chk("sv_force_arm_ready", arm_ready, 0);
        chk("sv_force_mem_we", mem_we, 1);
        chk("sv_force_mem_addr", mem_addr, 6);
        chk("sv_force_mem_wdata", mem_wdata, 32'h77);
        tick(); settle();
        chk("sv_after_arm_ready", arm_ready, 1);
        chk("sv_after_count", kq_count, 0);
        arm_req = 1'b0;
`else
        for (int i = 0; i < 12; i++) begin
            settle();
            chk($sformatf("sv_wait%0d_arm_ready", i), arm_ready, 1);
            chk($sformatf("sv_wait%0d_mem_we", i), mem_we, 0);
            chk($sformatf("sv_wait%0d_count", i), kq_count, 1);
            tick();
        end
        arm_req = 1'b0; settle();
        chk("sv_release_mem_we", mem_we, 1);
        chk("sv_release_mem_addr", mem_addr, 6);
        tick(); settle();
        chk("sv_release_count", kq_count, 0);
`endif

        // Five consecutive offers while the CPU holds the port
        arm_req = 1'b1; arm_addr = 0; tick();
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_addr = ADDR_W'(8 + i); key_data = DATA_W'(32'h100 + i); settle();
            chk($sformatf("ovf_offer%0d_ready", i), key_ready, (i < 4) ? 1 : 0);
            chk($sformatf("ovf_offer%0d_count", i), kq_count, (i < 4) ? i : 4);
            chk($sformatf("ovf_offer%0d_flag", i), key_ovf, 0);
            tick();
        end
        key_valid = 1'b0; settle();
        chk("ovf_flag_set", key_ovf, 1);
        chk("ovf_count_full", kq_count, 4);

        // Drain one entry: oldest first
        arm_req = 1'b0; settle();
        chk("order_mem_addr", mem_addr, 8);
        chk("order_mem_wdata", mem_wdata, 32'h100);
        tick(); arm_req = 1'b1; settle();
        chk("order_count3", kq_count, 3);
        chk("ovf_sticky", key_ovf, 1);

        // Reset with three entries queued
        rst_n = 1'b0; settle();
        chk("rst2_mem_we", mem_we, 0);
        chk("rst2_arm_ready", arm_ready, 0);
        chk("rst2_key_ready", key_ready, 0);
        tick(); settle();
        chk("rst2_count", kq_count, 0);
        chk("rst2_ovf", key_ovf, 0);
        rst_n = 1'b1; arm_req = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("rst2_idle%0d_mem_we", i), mem_we, 0);
            chk($sformatf("rst2_idle%0d_count", i), kq_count, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
